// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls and the IMEM word come in,
// the IMEM address and the IF/ID pipeline register go out.
interface instruction_fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        halted;
  logic        misalign;
  logic [31:0] fetch_count;

  modport master (
    input  stall, flush, branch_taken, branch_target, Instruction,
    output Inst_Address, if_id_pc, if_id_instruction, if_id_valid,
           halted, misalign, fetch_count
  );

  modport slave (
    output stall, flush, branch_taken, branch_target, Instruction,
    input  Inst_Address, if_id_pc, if_id_instruction, if_id_valid,
           halted, misalign, fetch_count
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Pipeline IF stage: owns the PC, fetches from IMEM and fills the IF/ID register.
// Define IF_MISALIGN_TRAP_EN to halt (sticky misalign flag) on unaligned redirects.
//
// state | meaning
// RUN   | fetching, PC advancing while in the populated IMEM range
// HALT  | PC ran off the end or trapped; bubbles until a redirect
module instruction_fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned IMEM_BYTES = 96,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic clk,
  input  logic reset,
  instruction_fetch_stage_if.master bus
);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES) - 64'd4;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic        bad_target;
  logic        hold;
  logic [63:0] aligned_target;

  assign aligned_target = bus.branch_target & ~64'd3;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q;

  assign bad_target   = bus.branch_target[1:0] != 2'b00;
  assign bus.misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (reset)
      misalign_q <= 1'b0;
    else if (bus.branch_taken && bad_target)
      misalign_q <= 1'b1;
  end
`else
  assign bad_target   = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  // Only a stall in RUN without a redirect keeps IF/ID; everything else rewrites it.
  assign hold = (state == S_RUN) && !bus.branch_taken && bus.stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_RUN;
      pc                <= RESET_PC;
      if_id_pc          <= 64'd0;
      if_id_instruction <= NOP_WORD;
      if_id_valid       <= 1'b0;
      fetch_count       <= 32'd0;
    end else begin
      if (!hold) begin
        if_id_pc          <= pc;
        if_id_instruction <= NOP_WORD;
        if_id_valid       <= 1'b0;
      end
      case (state)
        S_RUN: begin
          if (bus.branch_taken) begin
            if (bad_target) state <= S_HALT;
            else            pc    <= aligned_target;
          end else if (bus.stall) begin
            pc <= pc;
          end else if (pc > LAST_PC) begin
            state <= S_HALT;
          end else if (bus.flush) begin
            pc <= pc + 64'd4;
          end else begin
            if_id_instruction <= bus.Instruction;
            if_id_valid       <= 1'b1;
            pc                <= pc + 64'd4;
            fetch_count       <= fetch_count + 32'd1;
          end
        end
        S_HALT: begin
          if (bus.branch_taken && !bad_target) begin
            pc    <= aligned_target;
            state <= S_RUN;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign bus.Inst_Address      = pc;
  assign bus.if_id_pc          = if_id_pc;
  assign bus.if_id_instruction = if_id_instruction;
  assign bus.if_id_valid       = if_id_valid;
  assign bus.halted            = (state == S_HALT);
  assign bus.fetch_count       = fetch_count;

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Pipeline IF stage: it owns the program counter, drives the byte address into the 64-bit-address/32-bit-word instruction memory, and registers the returned word into the IF/ID pipeline register for the decoder. It handles stall, flush and branch redirect from downstream stages. It stops fetching cleanly when the PC leaves the populated instruction-memory range.

## Interface
Parameters:
- RESET_PC, 64'd0: PC loaded on reset.
- IMEM_BYTES, 96: instruction-memory size in bytes. Fetch is legal only while pc ≤ IMEM_BYTES−4.
- NOP_WORD, 32'h00000013: word placed in the IF/ID register for a bubble (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard-unit stall; hold PC and IF/ID contents.
- flush  in  1  kill the IF/ID contents (bubble); PC still advances.
- branch_taken  in  1  redirect request from EX.
- branch_target  in  64  redirect byte address.
- Inst_Address  out  64  fetch address to instruction memory; equals pc.
- Instruction  in  32  combinational word returned by instruction memory.
- if_id_pc  out  64  PC of the registered instruction.
- if_id_instruction  out  32  registered instruction word.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- halted  out  1  fetch stopped (state HALT).
- misalign  out  1  sticky misaligned-redirect flag (see Configuration).
- fetch_count  out  32  number of valid instructions delivered to IF/ID.

## Operation
- States: RUN and HALT. Reset enters RUN.
- RUN, in priority order each edge:
  - branch_taken: pc ← branch_target, IF/ID ← bubble.
  - Else stall: pc and IF/ID hold.
  - Else pc out of range (pc > IMEM_BYTES−4): state ← HALT, IF/ID ← bubble, pc holds.
  - Else flush: pc ← pc+4, IF/ID ← bubble.
  - Else: IF/ID ← {pc, Instruction, valid=1}, pc ← pc+4, fetch_count ← fetch_count+1.
- HALT:
  - IF/ID ← bubble every edge.
  - branch_taken: pc ← branch_target, state ← RUN. This covers a branch already in flight when fetch ran off the end.
  - stall and flush are ignored.
- Bubble contents: if_id_instruction=NOP_WORD, if_id_valid=0, if_id_pc=pc at that edge.
- Arithmetic:
  - pc+4 is 64-bit unsigned and wraps modulo 2^64.
  - fetch_count is 32-bit and wraps to 0 after 2^32−1.
- The range check uses the current pc, not the next pc.

## Timing
- Reset values: pc=RESET_PC, Inst_Address=RESET_PC, if_id_pc=0, if_id_instruction=NOP_WORD, if_id_valid=0, halted=0, misalign=0, fetch_count=0, state=RUN.
- Reset mid-operation overrides everything on the same edge, including branch_taken and a pending HALT.
- Inst_Address is a direct register output with no combinational path from any input. Instruction is sampled at the same edge that advances pc.
- Fetch-to-IF/ID latency: 1 cycle. The word at address A appears on if_id_* one edge after pc=A.
- Redirect penalty:
  - Edge of branch_taken: bubble.
  - Next edge: target instruction.
- Simultaneous branch_taken+stall: the branch wins.
- Simultaneous flush+stall: the stall wins (hold).
- halted equals (state==HALT), registered, and asserts on the edge the out-of-range pc is seen.

## Configuration
- Macro IF_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with branch_target[1:0]≠0 does not load pc.
  - It sets misalign (sticky until reset), enters HALT and writes a bubble.
- Undefined:
  - pc ← {branch_target[63:2],2'b00}.
  - misalign is tied to 0.

## Test plan
- Reset sequence: hold reset 2 cycles, release, with memory holding 32'h10000513 at 0 and 32'h00500293 at 4.
  - Edge 1: if_id_pc=0, if_id_instruction=32'h10000513, valid=1.
  - Edge 2: if_id_pc=4, word 32'h00500293.
  - fetch_count=2.
- Stall: assert stall 3 cycles while pc=8 → Inst_Address stays 8, IF/ID holds pc=4 data, fetch_count does not change; fetch resumes with pc=8.
- Branch + stall: at pc=20 assert branch_taken and stall with target 12.
  - Next edge: bubble (valid=0, NOP_WORD).
  - Following edge: if_id_pc=12, word 32'h045b0463.
- Run off end: IMEM_BYTES=96, no branches.
  - After pc=92 is delivered: halted=1 at pc=96, IF/ID bubbles.
  - Then branch_taken to 0 → halted=0, then the word at 0 is delivered.
- Misaligned redirect: target 64'h42.
  - With IF_MISALIGN_TRAP_EN: misalign=1, halted=1, pc unchanged.
  - Without the macro: pc=64'h40 and misalign=0.
- Reset mid-run: assert reset together with branch_taken at pc=40 → next edge pc=RESET_PC, valid=0, fetch_count=0.
